// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with prioritised redirect and an optional return-address stack.
// The RAS is built only when the PC_RAS_EN macro is defined; otherwise rasTop/rasValid tie to 0.
`default_nettype none

module pc_gen #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
   parameter int          RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [XLEN-1:0] branchImmEx,
   input  logic [25:0]     jumpImm,
   input  logic [XLEN-1:0] jumpReg,
   input  logic [XLEN-1:0] epc,
   input  logic            takeException,
   input  logic            takeEret,
   input  logic            takeBranch,
   input  logic            takeJumpImm,
   input  logic            takeJumpReg,
   input  logic            isCall,
   input  logic            isRet,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   output logic            redirect,
   output logic            addrErr,
   output logic [XLEN-1:0] rasTop,
   output logic            rasValid
);

   localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);
   localparam logic [XLEN-1:0] EXC_PC = XLEN'(EXC_VEC);

   logic [XLEN-1:0] branch_target;
   logic [XLEN-1:0] jump_target;
   logic [XLEN-1:0] pc_next;
   logic            redirect_next;

   assign pc4           = pc + XLEN'(4);
   assign branch_target = pc + (branchImmEx << 2);
   assign addrErr       = |pc[1:0];

   // J-type keeps the current 256 MB region; at the minimum width there are no region bits.
   generate
      if (XLEN > 28) begin : g_jt_region
         assign jump_target = {pc[XLEN-1:28], jumpImm, 2'b00};
      end else begin : g_jt_flat
         assign jump_target = {jumpImm, 2'b00};
      end
   endgenerate

   always_comb begin
      pc_next       = pc4;
      redirect_next = 1'b0;
      if (takeException) begin
         pc_next       = EXC_PC;
         redirect_next = 1'b1;
      end else if (takeEret) begin
         pc_next       = epc;
         redirect_next = 1'b1;
      end else if (stall) begin
         pc_next       = pc;
      end else if (takeBranch) begin
         pc_next       = branch_target;
         redirect_next = 1'b1;
      end else if (takeJumpImm) begin
         pc_next       = jump_target;
         redirect_next = 1'b1;
      end else if (takeJumpReg) begin
         pc_next       = jumpReg;
         redirect_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RST_PC;
         redirect <= 1'b0;
      end else begin
         pc       <= pc_next;
         redirect <= redirect_next;
      end
   end

`ifdef PC_RAS_EN
   localparam int          PW   = $clog2(RAS_DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   ras_ptr_inc;
   logic [PW:0]     ras_count;
   logic [XLEN-1:0] pc8;
   logic            ras_ok;
   logic            ras_push;
   logic            ras_pop;

   assign pc8         = pc + XLEN'(8);
   assign ras_ptr_inc = ras_ptr + PW'(1);
   assign ras_ok      = !stall && !takeException && !takeEret;
   assign ras_push    = ras_ok && isCall && (takeJumpImm || takeJumpReg);
   assign ras_pop     = ras_ok && isRet && takeJumpReg;

   // Pointer wraps at the power-of-two depth, so a push when full overwrites the oldest entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (ras_push && !ras_pop) begin
         ras_ptr <= ras_ptr_inc;
         if (ras_count != FULL) begin
            ras_count <= ras_count + (PW+1)'(1);
         end
      end else if (ras_pop && !ras_push && ras_count != '0) begin
         ras_ptr   <= ras_ptr - PW'(1);
         ras_count <= ras_count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[ras_pop ? ras_ptr : ras_ptr_inc] <= pc8;
      end
   end

   assign rasValid = (ras_count != '0);
   assign rasTop   = rasValid ? ras_mem[ras_ptr] : '0;
`else
   logic unused_ras;
   assign unused_ras = &{1'b0, isCall, isRet};
   assign rasTop     = '0;
   assign rasValid   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table for next-PC selection plus sequences for reset and the RAS.
`default_nettype none

module tb_pc_gen;

`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] branchImmEx = '0;
   logic [25:0] jumpImm = '0;
   logic [31:0] jumpReg = '0;
   logic [31:0] epc = '0;
   logic        takeException = 1'b0;
   logic        takeEret = 1'b0;
   logic        takeBranch = 1'b0;
   logic        takeJumpImm = 1'b0;
   logic        takeJumpReg = 1'b0;
   logic        isCall = 1'b0;
   logic        isRet = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        redirect;
   logic        addrErr;
   logic [31:0] rasTop;
   logic        rasValid;

   int n_checks = 0;
   int n_fail   = 0;

   pc_gen dut (
      .clk(clk), .rst(rst), .stall(stall), .branchImmEx(branchImmEx), .jumpImm(jumpImm),
      .jumpReg(jumpReg), .epc(epc), .takeException(takeException), .takeEret(takeEret),
      .takeBranch(takeBranch), .takeJumpImm(takeJumpImm), .takeJumpReg(takeJumpReg),
      .isCall(isCall), .isRet(isRet), .pc(pc), .pc4(pc4), .redirect(redirect),
      .addrErr(addrErr), .rasTop(rasTop), .rasValid(rasValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, exc, eret, br, jmpi, jmpr;
      logic [31:0] bimm;
      logic [25:0] jfield;
      logic [31:0] jr, ep;
      logic [31:0] exp_pc;
      logic        exp_red, exp_aerr;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      stall = 0; takeException = 0; takeEret = 0; takeBranch = 0; takeJumpImm = 0;
      takeJumpReg = 0; isCall = 0; isRet = 0; branchImmEx = '0; jumpImm = '0;
      jumpReg = '0; epc = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      clear_in(); takeJumpReg = 1; jumpReg = a; step(); clear_in();
   endtask

   task automatic do_call();
      clear_in(); takeJumpImm = 1; isCall = 1; jumpImm = 26'h0000400; step(); clear_in();
   endtask

   task automatic chk_ras(input string name, input logic [31:0] top, input logic valid);
      chk({name, "_top"}, rasTop, RAS_ON ? top : 32'h0);
      chk({name, "_valid"}, {31'b0, rasValid}, {31'b0, RAS_ON ? valid : 1'b0});
   endtask

   initial begin
      logic [31:0] pops [4];
      //           stall exc eret br jmpi jmpr bimm          jfield        jr            ep            exp_pc        red aerr
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'hBFC00004, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'hBFC00008, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 1, 32'h0,        26'h0,        32'hBFC00010, 32'h0,        32'hBFC00010, 1, 0};
      tbl[3]  = '{1, 1, 1, 1, 1, 1, 32'h0,        26'h0,        32'h00001234, 32'h80001000, 32'hBFC00380, 1, 0};
      tbl[4]  = '{1, 0, 1, 1, 1, 1, 32'h0,        26'h0,        32'h00001234, 32'h80001000, 32'h80001000, 1, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'h80001000, 0, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 1, 32'h0,        26'h0,        32'h00400000, 32'h0,        32'h00400000, 1, 0};
      tbl[7]  = '{0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 26'h0,        32'h0,        32'h0,        32'h003FFFFC, 1, 0};
      tbl[8]  = '{0, 0, 0, 0, 1, 0, 32'h0,        26'h0100000,  32'h0,        32'h0,        32'h00400000, 1, 0};
      tbl[9]  = '{1, 0, 0, 1, 0, 0, 32'h4,        26'h0,        32'h0,        32'h0,        32'h00400000, 0, 0};
      tbl[10] = '{0, 0, 0, 1, 0, 0, 32'h4,        26'h0,        32'h0,        32'h0,        32'h00400010, 1, 0};
      tbl[11] = '{0, 0, 0, 1, 1, 0, 32'h1,        26'h3FFFFFF,  32'h0,        32'h0,        32'h00400014, 1, 0};
      tbl[12] = '{0, 0, 0, 0, 1, 1, 32'h0,        26'h0000040,  32'hDEAD0000, 32'h0,        32'h00000100, 1, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 1, 32'h0,        26'h0,        32'h00400002, 32'h0,        32'h00400002, 1, 1};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'h00400006, 0, 1};
      tbl[15] = '{0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'hBFC00380, 1, 0};
      tbl[16] = '{1, 0, 1, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h80000003, 32'h80000003, 1, 1};
      tbl[17] = '{0, 0, 0, 0, 1, 0, 32'h0,        26'h3FFFFFF,  32'h0,        32'h0,        32'h8FFFFFFC, 1, 0};
      tbl[18] = '{0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'h90000000, 0, 0};
      tbl[19] = '{0, 0, 0, 0, 0, 1, 32'h0,        26'h0,        32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 1, 0};
      tbl[20] = '{0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        32'h00000000, 0, 0};
      tbl[21] = '{0, 0, 0, 1, 0, 0, 32'h7FFFFFFF, 26'h0,        32'h0,        32'h0,        32'hFFFFFFFC, 1, 0};

      // Reset state
      clear_in();
      rst = 0;
      step(); step();
      chk("reset_pc", pc, 32'hBFC00000);
      chk("reset_pc4", pc4, 32'hBFC00004);
      chk("reset_redirect", {31'b0, redirect}, 32'h0);
      chk("reset_addrErr", {31'b0, addrErr}, 32'h0);
      chk("reset_rasValid", {31'b0, rasValid}, 32'h0);
      chk("reset_rasTop", rasTop, 32'h0);
      rst = 1;

      for (int i = 0; i < 22; i++) begin
         stall = tbl[i].stall; takeException = tbl[i].exc; takeEret = tbl[i].eret;
         takeBranch = tbl[i].br; takeJumpImm = tbl[i].jmpi; takeJumpReg = tbl[i].jmpr;
         branchImmEx = tbl[i].bimm; jumpImm = tbl[i].jfield; jumpReg = tbl[i].jr; epc = tbl[i].ep;
         step();
         chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("vec%0d_pc4", i), pc4, tbl[i].exp_pc + 32'd4);
         chk($sformatf("vec%0d_redirect", i), {31'b0, redirect}, {31'b0, tbl[i].exp_red});
         chk($sformatf("vec%0d_addrErr", i), {31'b0, addrErr}, {31'b0, tbl[i].exp_aerr});
      end

      // Asynchronous reset mid-stream while a redirect is pending
      clear_in();
      #2 rst = 0;
      #1;
      chk("async_rst_pc", pc, 32'hBFC00000);
      chk("async_rst_redirect", {31'b0, redirect}, 32'h0);
      step();
      chk("in_rst_pc", pc, 32'hBFC00000);
      rst = 1;
      step();
      chk("post_rst_pc", pc, 32'hBFC00004);
      chk("post_rst_redirect", {31'b0, redirect}, 32'h0);

      // RAS: five calls into a depth-4 stack
      for (int k = 1; k <= 5; k++) begin
         goto_pc(32'h100 * k);
         do_call();
         chk_ras($sformatf("call%0d", k), 32'h100 * k + 32'h8, 1'b1);
      end
      pops[0] = 32'h508; pops[1] = 32'h408; pops[2] = 32'h308; pops[3] = 32'h208;
      for (int k = 0; k < 4; k++) begin
         chk_ras($sformatf("pre_pop%0d", k), pops[k], 1'b1);
         clear_in(); takeJumpReg = 1; isRet = 1; jumpReg = 32'h2000; step();
      end
      chk_ras("after_4_pops", 32'h0, 1'b0);
      clear_in(); takeJumpReg = 1; isRet = 1; jumpReg = 32'h2000; step();
      chk_ras("pop_empty", 32'h0, 1'b0);

      // Calls that must not push
      clear_in(); isCall = 1; step();
      chk_ras("call_no_take", 32'h0, 1'b0);
      clear_in(); isCall = 1; takeBranch = 1; branchImmEx = 32'h4; step();
      chk_ras("call_branch", 32'h0, 1'b0);
      clear_in(); isCall = 1; takeJumpImm = 1; stall = 1; step();
      chk_ras("call_stalled", 32'h0, 1'b0);
      clear_in(); isCall = 1; takeJumpReg = 1; takeException = 1; step();
      chk_ras("call_exception", 32'h0, 1'b0);

      // Exception does not flush; push+pop replaces top
      goto_pc(32'h200);
      do_call();
      chk_ras("rebuild", 32'h208, 1'b1);
      clear_in(); takeException = 1; step();
      chk_ras("exc_keeps", 32'h208, 1'b1);
      goto_pc(32'h600);
      clear_in(); isCall = 1; isRet = 1; takeJumpReg = 1; jumpReg = 32'h3000; step();
      chk_ras("push_pop", 32'h608, 1'b1);
      clear_in(); takeJumpReg = 1; isRet = 1; jumpReg = 32'h2000; step();
      chk_ras("count_kept", 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
